// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// The checksum option is selected with the LOADER_CHECKSUM_EN macro in instr_loader.sv.
package loader_pkg;

    localparam int IMEM_DEPTH       = 32;
    localparam int IMEM_AW          = 5;
    localparam int IMEM_DW          = 16;
    localparam int LOADER_MAX_WORDS = IMEM_DEPTH;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_t;

    // A header is usable when it asks for at least one word and no more than the memory holds.
    function automatic logic hdr_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

    function automatic logic ready_state(input loader_state_t s);
        return (s == ST_HDR) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Loads a framed byte-stream program image into the 32 x 16-bit instruction memory.
// Define LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW,
    parameter int DW    = IMEM_DW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_in_data,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [DW-1:0] o_imem_wdata,
    output logic          o_cpu_hold,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    output logic [AW:0]   o_words_loaded
);

    loader_state_t r_state;
    loader_state_t w_next;

    logic          r_in_ready;
    logic          r_imem_we;
    logic [AW-1:0] r_imem_addr;
    logic [DW-1:0] r_imem_wdata;
    logic          r_cpu_hold;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic [AW:0]   r_words_loaded;
    logic [AW:0]   r_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    r_acc;
`endif

    logic w_accept;
    logic w_hdr_ok;
    logic w_last;

    assign w_accept = i_in_valid && r_in_ready;
    assign w_hdr_ok = hdr_ok(i_in_data, DEPTH);
    assign w_last   = ((r_words_loaded + {{AW{1'b0}}, 1'b1}) == r_n);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; input gaps leave the state unchanged.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_start) w_next = ST_HDR;
                else         w_next = r_state;
            end
            ST_HDR: begin
                if (w_accept) w_next = w_hdr_ok ? ST_HI : ST_ERR;
                else          w_next = ST_HDR;
            end
            ST_HI: begin
                if (w_accept) w_next = ST_LO;
                else          w_next = ST_HI;
            end
            ST_LO: begin
                if (w_accept) w_next = ST_WRITE;
                else          w_next = ST_LO;
            end
            ST_WRITE: begin
`ifdef LOADER_CHECKSUM_EN
                if (w_last) w_next = ST_CHK;
`else
                if (w_last) w_next = ST_DONE;
`endif
                else        w_next = ST_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (w_accept) w_next = (r_acc == i_in_data) ? ST_DONE : ST_ERR;
                else          w_next = ST_CHK;
            end
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs; ready/we are precomputed from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_ready     <= 1'b0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= {AW{1'b0}};
            r_imem_wdata   <= {DW{1'b0}};
            r_cpu_hold     <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= {(AW+1){1'b0}};
            r_n            <= {(AW+1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            r_acc          <= 8'h00;
`endif
        end else begin
            r_in_ready <= ready_state(w_next);
            r_imem_we  <= (w_next == ST_WRITE);
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_start) begin
                        r_done         <= 1'b0;
                        r_error        <= 1'b0;
                        r_words_loaded <= {(AW+1){1'b0}};
                        r_imem_addr    <= {AW{1'b0}};
                        r_cpu_hold     <= 1'b1;
                        r_busy         <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        r_acc          <= 8'h00;
`endif
                    end
                end
                ST_HDR: begin
                    if (w_accept) begin
                        if (w_hdr_ok) begin
                            r_n <= i_in_data[AW:0];
                        end else begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        r_imem_wdata[DW-1:DW-8] <= i_in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_acc <= r_acc ^ i_in_data;
`endif
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_imem_wdata[7:0] <= i_in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_acc <= r_acc ^ i_in_data;
`endif
                    end
                end
                ST_WRITE: begin
                    r_words_loaded <= r_words_loaded + {{AW{1'b0}}, 1'b1};
                    if (!w_last) begin
                        r_imem_addr <= r_imem_addr + {{(AW-1){1'b0}}, 1'b1};
                    end
`ifndef LOADER_CHECKSUM_EN
                    else begin
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                // A bad checksum keeps the CPU held so a corrupt image never runs.
                ST_CHK: begin
                    if (w_accept) begin
                        r_busy <= 1'b0;
                        if (r_acc == i_in_data) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_imem_we      = r_imem_we;
    assign o_imem_addr    = r_imem_addr;
    assign o_imem_wdata   = r_imem_wdata;
    assign o_cpu_hold     = r_cpu_hold;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_words_loaded = r_words_loaded;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random frames against an outcome model of the frame rules.
module tb_instr_loader;
    import loader_pkg::*;

`ifdef LOADER_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    logic                 clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_start = 1'b0;
    logic [7:0]           i_in_data = 8'h00;
    logic                 i_in_valid = 1'b0;
    logic                 o_in_ready, o_imem_we, o_cpu_hold, o_busy, o_done, o_error;
    logic [IMEM_AW-1:0]   o_imem_addr;
    logic [IMEM_DW-1:0]   o_imem_wdata;
    logic [IMEM_AW:0]     o_words_loaded;

    instr_loader dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_in_data(i_in_data),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .o_imem_we(o_imem_we),
        .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata), .o_cpu_hold(o_cpu_hold),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_words_loaded(o_words_loaded)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [20:0] wr_q[$];
    int          we_run_err = 0;
    int          rdy_during_we = 0;
    logic        prev_we = 1'b0;
    logic [15:0] ld_w[32];
    bit          exp_ok, exp_done;
    int          exp_n;
    int          start_cyc, idle_cyc;

    always @(posedge clk) cyc++;

    // Write-port monitor: collects writes and flags long pulses or ready during a write.
    always @(negedge clk) begin
        if (o_imem_we) begin
            wr_q.push_back({o_imem_addr, o_imem_wdata});
            if (prev_we) we_run_err++;
            if (o_in_ready) rdy_during_we++;
        end
        prev_we = o_imem_we;
    end

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int n;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        n = 0;
        repeat (gap) @(negedge clk);
        i_in_data  = b;
        i_in_valid = 1'b1;
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            tests++; fails++;
            $display("FAIL send_byte: in_ready=%0b required 1 within 50 cycles (byte %h)", o_in_ready, b);
        end else begin
            @(negedge clk);
        end
        i_in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        idle_cyc = cyc;
        tests++;
        if (o_busy) begin
            fails++;
            $display("FAIL wait_idle: busy=%0b required 0 within 200 cycles", o_busy);
        end
    endtask

    // Drives one frame and derives the expected outcome directly from the frame rules.
    task automatic run_frame(input logic [7:0] hdr, input int n, input logic [7:0] chk_xor,
                             input int max_gap, input bit poke);
        logic [7:0] x;
        x = 8'h00;
        wr_q.delete();
        we_run_err = 0;
        rdy_during_we = 0;
        exp_ok   = (hdr != 8'h00) && (int'(hdr) <= IMEM_DEPTH);
        exp_done = exp_ok && ((CHK_BYTES == 0) || (chk_xor == 8'h00));
        exp_n    = exp_ok ? int'(hdr) : 0;
        start_cyc = cyc;
        pulse_start();
        send_byte(hdr, max_gap);
        if (exp_ok) begin
            for (int i = 0; i < n; i++) begin
                send_byte(ld_w[i][15:8], max_gap);
                send_byte(ld_w[i][7:0], max_gap);
                x = x ^ ld_w[i][15:8] ^ ld_w[i][7:0];
                if (poke && i == n / 2) pulse_start();
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(x ^ chk_xor, max_gap);
`endif
        end
        wait_idle();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_busy, o_done,
             o_error, o_words_loaded} !== 33'd0) begin
            fails++;
            $display("FAIL reset_values: rdy=%0b we=%0b addr=%0d wdata=%h hold=%0b busy=%0b done=%0b err=%0b wl=%0d required all 0",
                     o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_busy, o_done, o_error, o_words_loaded);
        end
        i_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        ld_w[0] = 16'h0440;
        ld_w[1] = 16'h0441;
        run_frame(8'h02, 2, 8'h00, 0, 1'b0);
        tests++;
        if (wr_q.size() != 2) begin
            fails++; $display("FAIL basic_wr_count: got %0d required 2", wr_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (wr_q[i] !== {IMEM_AW'(i), ld_w[i]}) begin
                    fails++; $display("FAIL basic_write: got %h required %h", wr_q[i], {IMEM_AW'(i), ld_w[i]});
                end
            end
        end
        tests++;
        if ({o_done, o_error, o_cpu_hold, o_busy, o_words_loaded} !== {4'b1000, 6'd2}) begin
            fails++;
            $display("FAIL basic_status: done=%0b err=%0b hold=%0b busy=%0b wl=%0d required 1 0 0 0 2",
                     o_done, o_error, o_cpu_hold, o_busy, o_words_loaded);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        ld_w[0] = 16'h0440;
        ld_w[1] = 16'h0441;
        run_frame(8'h02, 2, 8'h01, 0, 1'b0);
        tests++;
        if (wr_q.size() != 2) begin
            fails++; $display("FAIL badchk_wr_count: got %0d required 2", wr_q.size());
        end
        tests++;
        if ({o_done, o_error, o_cpu_hold, o_busy} !== 4'b0110) begin
            fails++;
            $display("FAIL badchk_status: done=%0b err=%0b hold=%0b busy=%0b required 0 1 1 0",
                     o_done, o_error, o_cpu_hold, o_busy);
        end
    endtask
`endif

    task automatic test_bad_header();
        logic [7:0] hdrs[3];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h21;
        hdrs[2] = 8'($urandom_range(33, 255));
        for (int h = 0; h < 3; h++) begin
            run_frame(hdrs[h], 0, 8'h00, 2, 1'b0);
            repeat (3) @(negedge clk);
            tests++;
            if (wr_q.size() != 0) begin
                fails++; $display("FAIL badhdr_writes: hdr=%h got %0d required 0", hdrs[h], wr_q.size());
            end
            tests++;
            if ({o_done, o_error, o_cpu_hold, o_busy, o_words_loaded} !== {4'b0110, 6'd0}) begin
                fails++;
                $display("FAIL badhdr_status: hdr=%h done=%0b err=%0b hold=%0b busy=%0b wl=%0d required 0 1 1 0 0",
                         hdrs[h], o_done, o_error, o_cpu_hold, o_busy, o_words_loaded);
            end
        end
    endtask

    // Full-depth and back-to-back loads with random data, gaps and ignored mid-load starts.
    task automatic test_random_loads(input int count, input bit full);
        int n;
        for (int t = 0; t < count; t++) begin
            n = full ? IMEM_DEPTH : int'($urandom_range(1, IMEM_DEPTH));
            for (int i = 0; i < n; i++) ld_w[i] = 16'($urandom);
            run_frame(8'(n), n, 8'h00, 3, 1'b1);
            tests++;
            if (wr_q.size() != exp_n) begin
                fails++; $display("FAIL load_wr_count: n=%0d got %0d required %0d", n, wr_q.size(), exp_n);
            end else begin
                for (int i = 0; i < exp_n; i++) begin
                    tests++;
                    if (wr_q[i] !== {IMEM_AW'(i), ld_w[i]}) begin
                        fails++; $display("FAIL load_write: idx=%0d got %h required %h", i, wr_q[i], {IMEM_AW'(i), ld_w[i]});
                    end
                end
            end
            tests++;
            if (we_run_err != 0 || rdy_during_we != 0) begin
                fails++; $display("FAIL load_we_pulse: long_pulses=%0d ready_in_write=%0d required 0 0", we_run_err, rdy_during_we);
            end
            tests++;
            if ({o_done, o_error, o_cpu_hold, o_words_loaded} !== {exp_done, !exp_done, !exp_done, 6'(exp_n)}) begin
                fails++;
                $display("FAIL load_status: done=%0b err=%0b hold=%0b wl=%0d required %0b %0b %0b %0d",
                         o_done, o_error, o_cpu_hold, o_words_loaded, exp_done, !exp_done, !exp_done, exp_n);
            end
        end
    endtask

    task automatic test_throughput();
        int n;
        for (int t = 0; t < 3; t++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) ld_w[i] = 16'($urandom);
            run_frame(8'(n), n, 8'h00, 0, 1'b0);
            tests++;
            if (idle_cyc - (start_cyc + 1) != 1 + 3 * n + CHK_BYTES || o_done !== 1'b1) begin
                fails++;
                $display("FAIL throughput: n=%0d cycles=%0d done=%0b required %0d 1",
                         n, idle_cyc - (start_cyc + 1), o_done, 1 + 3 * n + CHK_BYTES);
            end
        end
    endtask

    task automatic test_reset_midload();
        for (int i = 0; i < 4; i++) ld_w[i] = 16'($urandom);
        wr_q.delete();
        pulse_start();
        tests++;
        if ({o_busy, o_cpu_hold, o_in_ready} !== 3'b111) begin
            fails++; $display("FAIL start_status: busy=%0b hold=%0b rdy=%0b required 1 1 1", o_busy, o_cpu_hold, o_in_ready);
        end
        send_byte(8'h04, 0);
        send_byte(ld_w[0][15:8], 1);
        send_byte(ld_w[0][7:0], 1);
        send_byte(ld_w[1][15:8], 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        tests++;
        if ({o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_busy, o_done,
             o_error, o_words_loaded} !== 33'd0) begin
            fails++;
            $display("FAIL midreset_values: rdy=%0b we=%0b addr=%0d wdata=%h hold=%0b busy=%0b wl=%0d required all 0",
                     o_in_ready, o_imem_we, o_imem_addr, o_imem_wdata, o_cpu_hold, o_busy, o_words_loaded);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (wr_q.size() != 1 || wr_q[0] !== {5'd0, ld_w[0]}) begin
            fails++; $display("FAIL midreset_writes: count=%0d required 1 with word %h", wr_q.size(), ld_w[0]);
        end
        test_random_loads(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_bad_header();
        test_random_loads(1, 1'b1);
        test_throughput();
        test_reset_midload();
        test_random_loads(4, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that fills the 32 × 16-bit instruction memory of the 8-bit processor from an external byte stream. It is the write-side counterpart of the instruction fetch path: it receives a framed program image over a valid/ready byte interface, assembles 16-bit instruction words, and drives the memory write port. It holds the CPU stalled (`cpu_hold`) from load start until the image is fully written and verified.

## Interface
- `DEPTH`, 32, instruction memory depth in words
- `AW`, 5, memory address width (log2 DEPTH)
- `DW`, 16, instruction word width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle pulse that begins a load
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader can accept a byte this cycle
- `imem_we`  out  1  instruction memory write enable
- `imem_addr`  out  AW  write address
- `imem_wdata`  out  DW  write data
- `cpu_hold`  out  1  stall processor PC/fetch
- `busy`  out  1  load in progress
- `done`  out  1  last load completed successfully (sticky)
- `error`  out  1  last load failed (sticky)
- `words_loaded`  out  AW+1  number of words written by the current/last load

## Operation
- Frame: header byte N (word count), then 2N data bytes (high byte first per word), then checksum byte = XOR of all 2N data bytes (header excluded).
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- States: IDLE, HDR, HI, LO, WRITE, CHK, DONE, ERR.
- IDLE: `start` → HDR; clear `done`, `error`, `words_loaded`, `imem_addr`, and the checksum accumulator; set `cpu_hold`, `busy`.
- HDR: accept N. N == 0 or N > DEPTH → ERR. Otherwise latch N → HI.
- HI: accept byte into `imem_wdata[15:8]` → LO.
- LO: accept byte into `imem_wdata[7:0]` → WRITE. Both data bytes are XORed into the accumulator on acceptance.
- WRITE: `imem_we`=1 for exactly one cycle; increment `words_loaded`. If `words_loaded`+1 == N → CHK; else increment `imem_addr` → HI.
- CHK: accept byte; on match → DONE, on mismatch → ERR.
- DONE: `done`=1, `cpu_hold`=0, `busy`=0; remain until `start`.
- ERR: `error`=1, `cpu_hold` stays 1 (CPU must not run a corrupt image), `busy`=0; remain until `start`.
- `start` in HDR/HI/LO/WRITE/CHK is ignored. `start` in DONE/ERR behaves as in IDLE, beginning a new load.
- Address never wraps: N ≤ DEPTH guarantees `imem_addr` ≤ DEPTH-1.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `cpu_hold`, `busy`, `done`, `error` = 0; `imem_addr`, `imem_wdata`, `words_loaded` = 0.
- Reset mid-load: immediate return to IDLE on the next edge; no further writes. Already-written words remain in memory.
- `in_ready` is a pure function of state: 1 in HDR/HI/LO/CHK, 0 otherwise (no combinational path from `in_valid`).
- `imem_addr`/`imem_wdata` are stable during the WRITE cycle.
- Throughput: 3 cycles per word with continuous `in_valid`. Minimum load of N words: 1 (HDR) + 3N + 1 (CHK) cycles after `start`, then DONE.
- Gaps in `in_valid` stall the FSM in its current state with no side effects.

## Configuration
- `LOADER_CHECKSUM_EN` defined: checksum byte is required and checked as above (CHK state present).
- Not defined: no checksum byte, no CHK state, no accumulator; WRITE of the last word → DONE directly. ERR is reachable only via a bad header.

## Structure
- Shared package `loader_pkg`: state enum `loader_state_t`, constants `IMEM_DEPTH`=32, `IMEM_AW`=5, `IMEM_DW`=16, `LOADER_MAX_WORDS`.
- Single module; no sub-module needed (byte assembly and checksum are a few registers).

## Test plan
- Bytes 02, 04, 40, 04, 41, 01 after `start` → writes addr0=0x0440, addr1=0x0441; `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same frame with checksum 0x00 → both words written, then `error`=1, `cpu_hold` stays 1, `done`=0.
- Header 0x00, then header 0x21 on restart → ERR each time, zero `imem_we` pulses.
- Full load N=32 with random words and random `in_valid` gaps → 32 writes to addr 0..31 in order, each `imem_we` pulse exactly 1 cycle, `in_ready`=0 during WRITE.
- `rst` asserted after 3 data bytes of an N=4 load → all outputs at reset values next cycle; exactly one write observed; a new `start` loads correctly.
- Built without `LOADER_CHECKSUM_EN`: bytes 01, 12, 34 → addr0=0x1234 written, `done`=1 the cycle after WRITE.
